arm_regfile_mp: RTL and testbench

Parametrised multi-port ARM register file with a block-transfer sequencer, the next-generation replacement for the two-read/one-write R0–R14 file in the decode/execute boundary of the core.
- Provides NUM_RD combinational read ports, one general write port and a registered PC-write notification; index PC_IDX is never stored and reads return pc_in + PC_OFFSET.
- Adds an LDM/STM register-list walker that steps through the set bits of a list, one register per accepted handshake.

---
 rtl/arm_regfile_mp_if.sv | 29 ++
 rtl/arm_regfile_mp.sv | 139 +++++++++++++
 tb/tb_arm_regfile_mp.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_regfile_mp_if.sv
// Burst/step handshake bundle between the decode-side controller and arm_regfile_mp.
// master = issuer of LDM/STM bursts, slave = register file sequencer.
interface arm_regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NREG = 1 << ADDR_W;

  logic              bl_valid;
  logic              bl_ready;
  logic [NREG-1:0]   bl_list;
  logic              bl_load;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_idx;
  logic [DATA_W-1:0] st_rdata;
  logic [DATA_W-1:0] st_wdata;
  logic              bl_done;

  modport master (
    output bl_valid, bl_list, bl_load, st_ready, st_wdata,
    input  bl_ready, st_valid, st_idx, st_rdata, bl_done
  );

  modport slave (
    input  bl_valid, bl_list, bl_load, st_ready, st_wdata,
    output bl_ready, st_valid, st_idx, st_rdata, bl_done
  );
endinterface

// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file with LDM/STM register-list sequencer; PC index is virtual.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
//
// state | meaning
// IDLE  | accepting a burst (bl_ready=1)
// RUN   | presenting one step per lowest remaining list bit
// DONE  | one-cycle bl_done pulse, then back to IDLE
module arm_regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 3,
  parameter int PC_IDX    = 15,
  parameter int PC_OFFSET = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  output logic                     pc_wr_valid,
  output logic [DATA_W-1:0]        pc_wr_data,
  arm_regfile_mp_if.slave          bl
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_OFF = DATA_W'(PC_OFFSET);
  localparam logic [NREG-1:0]   ONE    = {{(NREG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [NREG-1:0]   list_q, list_nx, list_rest;
  logic              load_q, load_nx;
  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] step_idx;
  logic              seq_we;
  logic [DATA_W-1:0] pc_rd;
  logic              st_ready_w;
  logic [DATA_W-1:0] st_wdata_w;

  assign st_ready_w = bl.st_ready;
  assign st_wdata_w = bl.st_wdata;
  assign pc_rd      = pc_in + PC_OFF;
  assign seq_we     = (state == RUN) && st_ready_w && load_q;
  assign list_rest  = list_q & (list_q - ONE);
  assign bl.st_idx  = step_idx;

  // Lowest set bit wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    step_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (list_q[i]) step_idx = ADDR_W'(i);
    end
  end

  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = regs[a];
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) v = wd;
    if (seq_we && step_idx == a) v = st_wdata_w;
`endif
    if (a == PC_A) v = pc_rd;
    return v;
  endfunction

  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd[k*DATA_W +: DATA_W] = rd_val(ra[k*ADDR_W +: ADDR_W]);
    end
    bl.st_rdata = rd_val(step_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      list_q <= '0;
      load_q <= 1'b0;
    end else begin
      state  <= state_nx;
      list_q <= list_nx;
      load_q <= load_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    list_nx     = list_q;
    load_nx     = load_q;
    bl.bl_ready = 1'b0;
    bl.st_valid = 1'b0;
    bl.bl_done  = 1'b0;
    case (state)
      IDLE: begin
        bl.bl_ready = 1'b1;
        if (bl.bl_valid) begin
          list_nx  = bl.bl_list;
          load_nx  = bl.bl_load;
          state_nx = (bl.bl_list == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        bl.st_valid = 1'b1;
        if (st_ready_w) begin
          list_nx = list_rest;
          if (list_rest == '0) state_nx = DONE;
        end
      end
      DONE: begin
        bl.bl_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer load beats the general port on a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wr_valid <= 1'b0;
      pc_wr_data  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      pc_wr_valid <= (seq_we && step_idx == PC_A) || (we && wa == PC_A);
      if (seq_we && step_idx == PC_A) pc_wr_data <= st_wdata_w;
      else if (we && wa == PC_A)      pc_wr_data <= wd;
      for (int i = 0; i < NREG; i++) begin
        if (i != PC_IDX) begin
          if (seq_we && step_idx == ADDR_W'(i)) regs[i] <= st_wdata_w;
          else if (we && wa == ADDR_W'(i))      regs[i] <= wd;
        end
      end
    end
  end
endmodule

// File: tb/tb_arm_regfile_mp.sv
// Scoreboard bench for arm_regfile_mp: directed scenarios followed by random traffic.
module tb_arm_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 3;
  localparam int NREG   = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [DATA_W-1:0] pc_in;
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic pc_wr_valid;
  logic [DATA_W-1:0] pc_wr_data;

  arm_regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

  arm_regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                   .PC_IDX(15), .PC_OFFSET(8)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .pc_in(pc_in),
    .we(we), .wa(wa), .wd(wd), .pc_wr_valid(pc_wr_valid),
    .pc_wr_data(pc_wr_data), .bl(bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_RD*DATA_W-1:0] rd;
    logic bl_ready;
    logic bl_done;
    logic st_valid;
    logic [ADDR_W-1:0] st_idx;
    logic [DATA_W-1:0] st_rdata;
    logic pcv;
    logic [DATA_W-1:0] pcd;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register values, pending step indices, a done flag.
  logic [DATA_W-1:0] mregs [NREG];
  int  bq[$];
  bit  mload, mdone, mpcv;
  logic [DATA_W-1:0] mpcd;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    bq.delete();
    mload = 1'b0; mdone = 1'b0; mpcv = 1'b0; mpcd = '0;
  endtask

  function automatic logic [DATA_W-1:0] mread(input int a, input bit sw, input int sidx);
    if (a == 15) return pc_in + 32'd8;
    if (BYP && sw && sidx == a) return bif.st_wdata;
    if (BYP && we && int'(wa) == a) return wd;
    return mregs[a];
  endfunction

  task automatic step();
    exp_t e;
    bit active, sw;
    int sidx;
    if (!rst_n) model_reset();
    active = bq.size() > 0;
    sidx   = active ? bq[0] : 0;
    sw     = active && bif.st_ready && mload;
    for (int k = 0; k < NUM_RD; k++)
      e.rd[k*DATA_W +: DATA_W] = mread(int'(ra[k*ADDR_W +: ADDR_W]), sw, sidx);
    e.bl_ready = !active && !mdone;
    e.bl_done  = mdone;
    e.st_valid = active;
    e.st_idx   = ADDR_W'(sidx);
    e.st_rdata = active ? mread(sidx, sw, sidx) : '0;
    e.pcv      = mpcv;
    e.pcd      = mpcd;
    expq.push_back(e);
    if (rst_n) begin
      if (sw && sidx == 15)          begin mpcv = 1'b1; mpcd = bif.st_wdata; end
      else if (we && int'(wa) == 15) begin mpcv = 1'b1; mpcd = wd; end
      else mpcv = 1'b0;
      if (we && int'(wa) != 15 && !(sw && sidx == int'(wa))) mregs[wa] = wd;
      if (sw && sidx != 15) mregs[sidx] = bif.st_wdata;
      if (mdone) mdone = 1'b0;
      else if (active) begin
        if (bif.st_ready) begin
          void'(bq.pop_front());
          if (bq.size() == 0) mdone = 1'b1;
        end
      end else if (bif.bl_valid) begin
        for (int i = 0; i < NREG; i++) if (bif.bl_list[i]) bq.push_back(i);
        mload = bif.bl_load;
        if (bq.size() == 0) mdone = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int k = 0; k < NUM_RD; k++)
          chk($sformatf("rd%0d", k), rd[k*DATA_W +: DATA_W], e.rd[k*DATA_W +: DATA_W]);
        chk("bl_ready", 32'(bif.bl_ready), 32'(e.bl_ready));
        chk("bl_done", 32'(bif.bl_done), 32'(e.bl_done));
        chk("st_valid", 32'(bif.st_valid), 32'(e.st_valid));
        if (e.st_valid) begin
          chk("st_idx", 32'(bif.st_idx), 32'(e.st_idx));
          chk("st_rdata", bif.st_rdata, e.st_rdata);
        end
        chk("pc_wr_valid", 32'(pc_wr_valid), 32'(e.pcv));
        chk("pc_wr_data", pc_wr_data, e.pcd);
      end
    end
  end

  task automatic quiet();
    we = 1'b0; wa = '0; wd = '0;
    bif.bl_valid = 1'b0; bif.bl_list = '0; bif.bl_load = 1'b0;
    bif.st_ready = 1'b0; bif.st_wdata = '0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int sr [4];
    sr = '{1, 0, 1, 1};
    rst_n = 1'b0;
    pc_in = 32'h100;
    ra = '0;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: sweep every index across the read ports.
    for (int b = 0; b < NREG; b += NUM_RD) begin
      ra = {4'(b + 2), 4'(b + 1), 4'(b)};
      step();
    end

    // Write R3, same-cycle and next-cycle reads.
    ra = {4'd3, 4'd3, 4'd3};
    we = 1'b1; wa = 4'd3; wd = 32'hDEADBEEF;
    step();
    we = 1'b0;
    step();

    // Write to PC index: notification only.
    we = 1'b1; wa = 4'd15; wd = 32'h2000;
    step();
    we = 1'b0; ra = {4'd15, 4'd15, 4'd3};
    step(); step();

    // STM 0x8005 with st_ready 1,0,1,1.
    bif.bl_valid = 1'b1; bif.bl_list = 16'h8005; bif.bl_load = 1'b0;
    step();
    bif.bl_valid = 1'b0; bif.bl_list = 16'hFFFF; bif.bl_load = 1'b1;
    foreach (sr[i]) begin
      bif.st_ready = sr[i][0];
      step();
    end
    quiet();
    step(); step();

    // LDM 0x0012 with a colliding general write on the second step.
    bif.bl_valid = 1'b1; bif.bl_list = 16'h0012; bif.bl_load = 1'b1;
    step();
    bif.bl_valid = 1'b0;
    bif.st_ready = 1'b1; bif.st_wdata = 32'hA;
    ra = {4'd4, 4'd1, 4'd4};
    step();
    bif.st_wdata = 32'hB;
    we = 1'b1; wa = 4'd4; wd = 32'hC;
    step();
    quiet();
    step(); step();

    // Empty list.
    bif.bl_valid = 1'b1; bif.bl_list = '0;
    step();
    bif.bl_valid = 1'b0;
    step(); step();

    // Reset during RUN.
    bif.bl_valid = 1'b1; bif.bl_list = 16'hFFFF; bif.bl_load = 1'b1;
    step();
    bif.bl_valid = 1'b0; bif.st_ready = 1'b1; bif.st_wdata = 32'h5555AAAA;
    ra = {4'd2, 4'd1, 4'd0};
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();

    // Random traffic.
    for (int c = 0; c < 700; c++) begin
      ra            = NUM_RD*ADDR_W'($urandom);
      pc_in         = $urandom;
      we            = 1'($urandom_range(0, 1));
      wa            = 4'($urandom_range(0, 15));
      wd            = $urandom;
      bif.bl_valid  = ($urandom_range(0, 3) == 0);
      bif.bl_list   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom & $urandom);
      bif.bl_load   = 1'($urandom_range(0, 1));
      bif.st_ready  = ($urandom_range(0, 2) != 0);
      bif.st_wdata  = $urandom;
      rst_n         = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    quiet();
    step();

    @(negedge clk); #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
